// File: rtl/pu_cbus_arb.sv
// -----------------------------------------------------------------------------
// pu_cbus_arb
//
// Shares the processor unit's single cache-bus port to L2 between the
// instruction-fetch requester (IA) and the memory-access requester (MA).
// In IDLE the arbiter picks a winner combinationally, grants it in the same
// cycle and registers its command/payload onto the cache bus. It then drives
// cbus_req until L2 acknowledges and waits for completion. Ack, rdy and read
// data are routed back to the owning requester only. One transaction is
// outstanding at a time, and there is a one-cycle IDLE bubble between
// back-to-back transactions.
//
// Parameters
//   CMD_W      cache-bus command width
//   ADDR_W     core byte-address width
//   DATA_W     cache-line beat width
//   BE_W       write byte-enable width (DATA_W/8)
//   PRIO_MODE  0 = round-robin between IA and MA; 1 = fixed priority, MA first
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   ia_req / ma_req          request; the payload is valid while high
//   *_cmd, *_addr            command and address of the request
//   *_wr_data_be, *_wr_data  write byte enables and write data
//   *_grt                    granted; payload captured this cycle
//   *_ack                    command accepted by L2 (owner only)
//   *_rdy                    transaction complete (owner only)
//   *_rd_data                read data, valid with *_rdy, otherwise 0
//   cbus_req                 request to L2, high while awaiting cbus_ack
//   cbus_cmd/addr/wr_data_be/wr_data   latched payload of the owner
//   cbus_ack, cbus_rdy       L2 accept / completion
//   cbus_rd_data             L2 read data, valid with cbus_rdy
//   busy                     high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module pu_cbus_arb #(
   parameter int CMD_W     = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int BE_W      = 16,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,

   // instruction-fetch requester
   input  logic              ia_req,
   input  logic [CMD_W-1:0]  ia_cmd,
   input  logic [ADDR_W-1:0] ia_addr,
   input  logic [BE_W-1:0]   ia_wr_data_be,
   input  logic [DATA_W-1:0] ia_wr_data,
   output logic              ia_grt,
   output logic              ia_ack,
   output logic              ia_rdy,
   output logic [DATA_W-1:0] ia_rd_data,

   // memory-access requester
   input  logic              ma_req,
   input  logic [CMD_W-1:0]  ma_cmd,
   input  logic [ADDR_W-1:0] ma_addr,
   input  logic [BE_W-1:0]   ma_wr_data_be,
   input  logic [DATA_W-1:0] ma_wr_data,
   output logic              ma_grt,
   output logic              ma_ack,
   output logic              ma_rdy,
   output logic [DATA_W-1:0] ma_rd_data,

   // cache bus towards L2
   output logic              cbus_req,
   output logic [CMD_W-1:0]  cbus_cmd,
   output logic [ADDR_W-1:0] cbus_addr,
   output logic [BE_W-1:0]   cbus_wr_data_be,
   output logic [DATA_W-1:0] cbus_wr_data,
   input  logic              cbus_ack,
   input  logic              cbus_rdy,
   input  logic [DATA_W-1:0] cbus_rd_data,

   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // arbitrating, nothing in flight
      ST_BUS  = 2'd1,   // cbus_req high, waiting for cbus_ack
      ST_DATA = 2'd2    // command accepted, waiting for cbus_rdy
   } state_e;

   typedef enum logic {
      REQ_IA = 1'b0,
      REQ_MA = 1'b1
   } req_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e              state_q,    state_d;
   req_e                last_grt_q, last_grt_d;
   req_e                owner_q,    owner_d;
   logic [CMD_W-1:0]    cmd_q,      cmd_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [BE_W-1:0]     be_q,       be_d;
   logic [DATA_W-1:0]   wdata_q,    wdata_d;

   // Arbitration result, meaningful only in IDLE.
   logic                win_valid;
   req_e                win;

   // Bus events qualified by state, before routing to the owner.
   logic                grt_hit;
   logic                ack_hit;
   logic                rdy_hit;

   // ---------------------------------------------------------------------------
   // Arbitration: sole requester wins; on a tie either the side that was not
   // granted last time (round-robin) or always MA (fixed priority).
   // ---------------------------------------------------------------------------
   always_comb begin
      win_valid = ia_req | ma_req;
      win       = REQ_IA;
      if (ia_req && ma_req) begin
         if (PRIO_MODE != 0) begin
            win = REQ_MA;
         end else begin
            win = (last_grt_q == REQ_MA) ? REQ_IA : REQ_MA;
         end
      end else if (ma_req) begin
         win = REQ_MA;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable driven here gets a default first so that no path
      // through the case statement leaves it unassigned and infers a latch.
      state_d    = state_q;
      last_grt_d = last_grt_q;
      owner_d    = owner_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      grt_hit    = 1'b0;
      ack_hit    = 1'b0;
      rdy_hit    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Stray cbus_ack/cbus_rdy are simply not looked at here.
            if (win_valid) begin
               grt_hit    = 1'b1;
               owner_d    = win;
               last_grt_d = win;
               state_d    = ST_BUS;
               if (win == REQ_MA) begin
                  cmd_d   = ma_cmd;
                  addr_d  = ma_addr;
                  be_d    = ma_wr_data_be;
                  wdata_d = ma_wr_data;
               end else begin
                  cmd_d   = ia_cmd;
                  addr_d  = ia_addr;
                  be_d    = ia_wr_data_be;
                  wdata_d = ia_wr_data;
               end
            end
         end

         ST_BUS: begin
            // A cbus_rdy without cbus_ack is stray and ignored; with cbus_ack
            // in the same cycle it completes the transaction immediately.
            if (cbus_ack) begin
               ack_hit = 1'b1;
               if (cbus_rdy) begin
                  rdy_hit = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            if (cbus_rdy) begin
               rdy_hit = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the values of the previous cycle regardless of statement order.
      if (rst) begin
         state_q    <= ST_IDLE;
         last_grt_q <= REQ_MA;    // IA wins the first round-robin tie
         owner_q    <= REQ_IA;
         cmd_q      <= '0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_grt_q <= last_grt_d;
         owner_q    <= owner_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Requester-side outputs. Grants follow the live arbitration result; ack,
   // rdy and read data go to the recorded owner only. All of them are held
   // low while rst is high: a grant during reset would never be captured, and
   // an abandoned transaction must not complete.
   // ---------------------------------------------------------------------------
   always_comb begin
      ia_grt     = 1'b0;
      ma_grt     = 1'b0;
      ia_ack     = 1'b0;
      ma_ack     = 1'b0;
      ia_rdy     = 1'b0;
      ma_rdy     = 1'b0;
      ia_rd_data = '0;
      ma_rd_data = '0;

      if (!rst) begin
         if (grt_hit) begin
            ia_grt = (win == REQ_IA);
            ma_grt = (win == REQ_MA);
         end
         if (ack_hit) begin
            ia_ack = (owner_q == REQ_IA);
            ma_ack = (owner_q == REQ_MA);
         end
         if (rdy_hit) begin
            if (owner_q == REQ_MA) begin
               ma_rdy     = 1'b1;
               ma_rd_data = cbus_rd_data;
            end else begin
               ia_rdy     = 1'b1;
               ia_rd_data = cbus_rd_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Cache-bus side outputs, all straight from registers.
   // ---------------------------------------------------------------------------
   assign cbus_req        = (state_q == ST_BUS);
   assign cbus_cmd        = cmd_q;
   assign cbus_addr       = addr_q;
   assign cbus_wr_data_be = be_q;
   assign cbus_wr_data    = wdata_q;
   assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pu_cbus_arb.sv
// -----------------------------------------------------------------------------
// tb_pu_cbus_arb
//
// Two arbiters share every input: u_rr uses round-robin, u_fp fixed priority.
// A transaction-level reference model (one per instance) predicts every output
// each cycle. Directed scenarios are followed by a randomized phase.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pu_cbus_arb;

   localparam int CMD_W  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 128;
   localparam int BE_W   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              ia_req,  ma_req;
   logic [CMD_W-1:0]  ia_cmd,  ma_cmd;
   logic [ADDR_W-1:0] ia_addr, ma_addr;
   logic [BE_W-1:0]   ia_be,   ma_be;
   logic [DATA_W-1:0] ia_wd,   ma_wd;
   logic              cbus_ack, cbus_rdy;
   logic [DATA_W-1:0] cbus_rd_data;

   // index 0 = round-robin instance, index 1 = fixed-priority instance
   logic              ia_grt [2], ia_ack [2], ia_rdy [2];
   logic              ma_grt [2], ma_ack [2], ma_rdy [2];
   logic [DATA_W-1:0] ia_rd_data [2], ma_rd_data [2];
   logic              cbus_req [2], busy [2];
   logic [CMD_W-1:0]  cbus_cmd [2];
   logic [ADDR_W-1:0] cbus_addr [2];
   logic [BE_W-1:0]   cbus_be [2];
   logic [DATA_W-1:0] cbus_wd [2];

   pu_cbus_arb #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
                 .PRIO_MODE(0)) u_rr (
      .clk(clk), .rst(rst),
      .ia_req(ia_req), .ia_cmd(ia_cmd), .ia_addr(ia_addr),
      .ia_wr_data_be(ia_be), .ia_wr_data(ia_wd),
      .ia_grt(ia_grt[0]), .ia_ack(ia_ack[0]), .ia_rdy(ia_rdy[0]),
      .ia_rd_data(ia_rd_data[0]),
      .ma_req(ma_req), .ma_cmd(ma_cmd), .ma_addr(ma_addr),
      .ma_wr_data_be(ma_be), .ma_wr_data(ma_wd),
      .ma_grt(ma_grt[0]), .ma_ack(ma_ack[0]), .ma_rdy(ma_rdy[0]),
      .ma_rd_data(ma_rd_data[0]),
      .cbus_req(cbus_req[0]), .cbus_cmd(cbus_cmd[0]), .cbus_addr(cbus_addr[0]),
      .cbus_wr_data_be(cbus_be[0]), .cbus_wr_data(cbus_wd[0]),
      .cbus_ack(cbus_ack), .cbus_rdy(cbus_rdy), .cbus_rd_data(cbus_rd_data),
      .busy(busy[0])
   );

   pu_cbus_arb #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
                 .PRIO_MODE(1)) u_fp (
      .clk(clk), .rst(rst),
      .ia_req(ia_req), .ia_cmd(ia_cmd), .ia_addr(ia_addr),
      .ia_wr_data_be(ia_be), .ia_wr_data(ia_wd),
      .ia_grt(ia_grt[1]), .ia_ack(ia_ack[1]), .ia_rdy(ia_rdy[1]),
      .ia_rd_data(ia_rd_data[1]),
      .ma_req(ma_req), .ma_cmd(ma_cmd), .ma_addr(ma_addr),
      .ma_wr_data_be(ma_be), .ma_wr_data(ma_wd),
      .ma_grt(ma_grt[1]), .ma_ack(ma_ack[1]), .ma_rdy(ma_rdy[1]),
      .ma_rd_data(ma_rd_data[1]),
      .cbus_req(cbus_req[1]), .cbus_cmd(cbus_cmd[1]), .cbus_addr(cbus_addr[1]),
      .cbus_wr_data_be(cbus_be[1]), .cbus_wr_data(cbus_wd[1]),
      .cbus_ack(cbus_ack), .cbus_rdy(cbus_rdy), .cbus_rd_data(cbus_rd_data),
      .busy(busy[1])
   );

   // ---------------------------------------------------------------------------
   // Counters and the single comparison point
   // ---------------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a transaction is either absent, issued (waiting for
   // L2 to accept) or accepted (waiting for completion). Requesters are
   // numbered 0 = IA, 1 = MA.
   // ---------------------------------------------------------------------------
   bit                in_flight [2];
   bit                accepted  [2];
   int                owner     [2];
   int                last_win  [2];
   logic [CMD_W-1:0]  m_cmd  [2];
   logic [ADDR_W-1:0] m_addr [2];
   logic [BE_W-1:0]   m_be   [2];
   logic [DATA_W-1:0] m_wd   [2];

   // Who would be granted right now; -1 when nobody asks.
   function automatic int pick(input int k);
      if (ia_req && ma_req) begin
         if (k == 1) return 1;
         return (last_win[k] == 1) ? 0 : 1;
      end
      if (ia_req) return 0;
      if (ma_req) return 1;
      return -1;
   endfunction

   task automatic check_models();
      for (int k = 0; k < 2; k++) begin
         bit   g_ia, g_ma, ack, rdy;
         int   w;
         logic [DATA_W-1:0] e_ia_rd, e_ma_rd;
         string s;
         g_ia = 0; g_ma = 0; ack = 0; rdy = 0;
         if (!rst) begin
            if (!in_flight[k]) begin
               w    = pick(k);
               g_ia = (w == 0);
               g_ma = (w == 1);
            end else if (!accepted[k]) begin
               ack = cbus_ack;
               rdy = cbus_ack && cbus_rdy;
            end else begin
               rdy = cbus_rdy;
            end
         end
         e_ia_rd = (rdy && owner[k] == 0) ? cbus_rd_data : '0;
         e_ma_rd = (rdy && owner[k] == 1) ? cbus_rd_data : '0;
         s = (k == 0) ? "rr" : "fp";
         check({s, ".ia_grt"},  ia_grt[k],  g_ia);
         check({s, ".ma_grt"},  ma_grt[k],  g_ma);
         check({s, ".ia_ack"},  ia_ack[k],  ack && owner[k] == 0);
         check({s, ".ma_ack"},  ma_ack[k],  ack && owner[k] == 1);
         check({s, ".ia_rdy"},  ia_rdy[k],  rdy && owner[k] == 0);
         check({s, ".ma_rdy"},  ma_rdy[k],  rdy && owner[k] == 1);
         check({s, ".ia_rd"},   ia_rd_data[k], e_ia_rd);
         check({s, ".ma_rd"},   ma_rd_data[k], e_ma_rd);
         check({s, ".cbus_req"}, cbus_req[k], in_flight[k] && !accepted[k]);
         check({s, ".busy"},    busy[k],    in_flight[k]);
         check({s, ".cmd"},     cbus_cmd[k],  m_cmd[k]);
         check({s, ".addr"},    cbus_addr[k], m_addr[k]);
         check({s, ".be"},      cbus_be[k],   m_be[k]);
         check({s, ".wd"},      cbus_wd[k],   m_wd[k]);
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         int w;
         if (rst) begin
            in_flight[k] = 0; accepted[k] = 0; owner[k] = 0; last_win[k] = 1;
            m_cmd[k] = '0; m_addr[k] = '0; m_be[k] = '0; m_wd[k] = '0;
         end else if (!in_flight[k]) begin
            w = pick(k);
            if (w >= 0) begin
               in_flight[k] = 1;
               accepted[k]  = 0;
               owner[k]     = w;
               last_win[k]  = w;
               m_cmd[k]  = (w == 1) ? ma_cmd  : ia_cmd;
               m_addr[k] = (w == 1) ? ma_addr : ia_addr;
               m_be[k]   = (w == 1) ? ma_be   : ia_be;
               m_wd[k]   = (w == 1) ? ma_wd   : ia_wd;
            end
         end else if (!accepted[k]) begin
            if (cbus_ack) begin
               if (cbus_rdy) in_flight[k] = 0;
               else          accepted[k]  = 1;
            end
         end else if (cbus_rdy) begin
            in_flight[k] = 0;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Cycle helpers
   // ---------------------------------------------------------------------------
   task automatic sample();
      @(negedge clk);
      check_models();
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      ia_req = 0; ma_req = 0; cbus_ack = 0; cbus_rdy = 0;
      ia_cmd = '0; ia_addr = '0; ia_be = '0; ia_wd = '0;
      ma_cmd = '0; ma_addr = '0; ma_be = '0; ma_wd = '0;
      cbus_rd_data = '0;
   endtask

   task automatic do_reset();
      rst = 1;
      advance();
      advance();
      rst = 0;
   endtask

   function automatic logic [DATA_W-1:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [DATA_W-1:0] beat_a5, beat_1234;
      beat_a5   = {16{8'hA5}};
      beat_1234 = {8{16'h1234}};

      quiet_inputs();
      do_reset();

      // Reset state
      sample();
      check("reset.busy", busy[0], 1'b0);
      check("reset.cbus_req", cbus_req[0], 1'b0);
      check("reset.addr", cbus_addr[0], 32'h0);
      advance();

      // IA-only read
      ia_req = 1; ia_cmd = 2'd0; ia_addr = 32'h0000_1040;
      sample();                                               // c0
      check("t1.ia_grt_c0", ia_grt[0], 1'b1);
      check("t1.ma_grt_c0", ma_grt[0], 1'b0);
      advance();
      ia_req = 0; ia_addr = 32'hDEAD_BEEF;
      sample();                                               // c1
      check("t1.cbus_req_c1", cbus_req[0], 1'b1);
      check("t1.addr_c1", cbus_addr[0], 32'h0000_1040);
      advance();
      sample(); advance();                                    // c2
      cbus_ack = 1;
      sample();                                               // c3
      check("t1.ia_ack_c3", ia_ack[0], 1'b1);
      check("t1.ma_ack_c3", ma_ack[0], 1'b0);
      advance();
      cbus_ack = 0;
      sample(); advance();                                    // c4
      cbus_rdy = 1; cbus_rd_data = beat_a5;
      sample();                                               // c5
      check("t1.ia_rdy_c5", ia_rdy[0], 1'b1);
      check("t1.ia_rd_c5", ia_rd_data[0], beat_a5);
      check("t1.ma_rd_c5", ma_rd_data[0], 128'h0);
      advance();
      cbus_rdy = 0; cbus_rd_data = '0;
      sample();
      check("t1.busy_end", busy[0], 1'b0);
      advance();

      // Both requesting continuously; L2 answers ack+rdy together in BUS
      do_reset();
      ia_req = 1; ma_req = 1;
      ia_addr = 32'h0000_0100; ma_addr = 32'h0000_0200;
      for (int i = 0; i < 4; i++) begin
         sample();
         check($sformatf("t2.rr_ia_grt%0d", i), ia_grt[0], (i % 2) == 0);
         check($sformatf("t2.rr_ma_grt%0d", i), ma_grt[0], (i % 2) == 1);
         check($sformatf("t2.fp_ma_grt%0d", i), ma_grt[1], 1'b1);
         advance();
         cbus_ack = 1; cbus_rdy = 1; cbus_rd_data = rand_beat();
         sample();
         check($sformatf("t3.rr_ack%0d", i),
               (i % 2 == 0) ? ia_ack[0] : ma_ack[0], 1'b1);
         check($sformatf("t3.rr_rdy%0d", i),
               (i % 2 == 0) ? ia_rdy[0] : ma_rdy[0], 1'b1);
         advance();
         cbus_ack = 0; cbus_rdy = 0;
      end
      quiet_inputs();
      sample(); advance();
      sample(); advance();

      // MA write: payload held in BUS after ma_req drops and data changes
      do_reset();
      ma_req = 1; ma_cmd = 2'd1; ma_addr = 32'h0000_2000;
      ma_be = 16'hFFFF; ma_wd = beat_1234;
      sample(); advance();
      ma_req = 0; ma_be = 16'h0; ma_wd = rand_beat();
      for (int i = 0; i < 3; i++) begin
         sample();
         check($sformatf("t4.wd%0d", i), cbus_wd[0], beat_1234);
         check($sformatf("t4.be%0d", i), cbus_be[0], 16'hFFFF);
         check($sformatf("t4.req%0d", i), cbus_req[0], 1'b1);
         advance();
         ma_wd = rand_beat();
      end
      cbus_ack = 1; sample(); advance();
      cbus_ack = 0; cbus_rdy = 1; cbus_rd_data = rand_beat();
      sample();
      check("t4.ma_rdy", ma_rdy[0], 1'b1);
      advance();
      quiet_inputs();

      // Reset asserted in DATA, then a late stray rdy
      ia_req = 1; ia_addr = 32'h0000_3000;
      sample(); advance();
      ia_req = 0; cbus_ack = 1;
      sample(); advance();
      cbus_ack = 0; rst = 1;
      sample(); advance();
      rst = 0;
      sample();
      check("t5.cbus_req", cbus_req[0], 1'b0);
      check("t5.busy", busy[0], 1'b0);
      advance();
      cbus_rdy = 1; cbus_rd_data = rand_beat();
      sample();
      check("t5.ia_rdy", ia_rdy[0], 1'b0);
      check("t5.ma_rdy", ma_rdy[0], 1'b0);
      advance();
      quiet_inputs();

      // Stray ack/rdy pulses in IDLE without requests
      for (int i = 0; i < 6; i++) begin
         cbus_ack = i[0]; cbus_rdy = i[1]; cbus_rd_data = rand_beat();
         sample();
         check($sformatf("t6.busy%0d", i), busy[0], 1'b0);
         advance();
      end
      quiet_inputs();

      // Randomized traffic, including stray events and the odd reset
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         ia_req   = $urandom_range(0, 1);
         ma_req   = $urandom_range(0, 1);
         ia_cmd   = CMD_W'($urandom); ma_cmd  = CMD_W'($urandom);
         ia_addr  = $urandom;         ma_addr = $urandom;
         ia_be    = BE_W'($urandom);  ma_be   = BE_W'($urandom);
         ia_wd    = rand_beat();      ma_wd   = rand_beat();
         cbus_ack = ($urandom_range(0, 2) == 0);
         cbus_rdy = ($urandom_range(0, 2) == 0);
         cbus_rd_data = rand_beat();
         sample();
         advance();
      end
      rst = 0;
      quiet_inputs();
      sample(); advance();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
